// File: rtl/nor_gate_sweep_ctrl.sv
// nor_gate_sweep_ctrl
// Walks all 16 input vectors of a four-input NOR datapath, holds each for
// DWELL cycles, samples the three NOR outputs on the last dwell cycle and
// accumulates pass/fail status for the whole sweep.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            sweep request, honoured only in IDLE and DONE
//   e, f, g          NOR outputs returned by the datapath under test
//   a, b, c, d       datapath inputs, {a,b,c,d} = current vector (0 when idle)
//   busy, done       sweep in progress / sweep finished
//   mismatch         sticky: at least one vector failed this sweep
//   fail_cnt         number of failing vectors (0..16)
//   fail_vec         first failing vector, 0 if none
//   err_mask         sticky per-output failure flags {g,f,e}
module nor_gate_sweep_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [4:0] fail_cnt,
  output logic [3:0] fail_vec,
  output logic [2:0] err_mask
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned VEC_W = 4;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(15);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] dwell;

  logic             launch;
  logic             sample;
  logic             exp_nor;
  logic [2:0]       out_err;

  // Vector register drives the datapath directly; it is zero outside RUN
  // because it is cleared on launch and wraps to 0 on the final sample.
  assign {a, b, c, d} = vec;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and sample/launch decode
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    sample  = 1'b0;
    exp_nor = ~(|vec);
    out_err = {g, f, e} ^ {3{exp_nor}};
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (dwell == DWELL_LAST) begin
          sample = 1'b1;
          if (vec == VEC_LAST) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep datapath, status accumulation and registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= '0;
      dwell    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      fail_vec <= '0;
      err_mask <= '0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      if (launch) begin
        vec      <= '0;
        dwell    <= '0;
        mismatch <= 1'b0;
        fail_cnt <= '0;
        fail_vec <= '0;
        err_mask <= '0;
      end else if (state_q == RUN) begin
        if (sample) begin
          dwell <= '0;
          vec   <= vec + VEC_W'(1);
          if (|out_err) begin
            fail_cnt <= fail_cnt + 5'd1;
            // First failure of the sweep is latched; later ones only count.
            if (!mismatch) fail_vec <= vec;
            mismatch <= 1'b1;
            err_mask <= err_mask | out_err;
          end
        end else begin
          dwell <= dwell + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nor_gate_sweep_ctrl.sv
// Bench for nor_gate_sweep_ctrl: a fault-injectable NOR datapath model
// (per-vector XOR error table) feeds the controller; expected status is
// derived from the error table by counting and scanning it.
module tb_nor_gate_sweep_ctrl;

  localparam int unsigned DWELL = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       e, f, g;
  logic       a, b, c, d;
  logic       busy, done, mismatch;
  logic [4:0] fail_cnt;
  logic [3:0] fail_vec;
  logic [2:0] err_mask;

  // flt[v] is XORed onto the ideal {g,f,e} for input vector v
  logic [2:0] flt [16];

  int checks = 0;
  int errors = 0;

  nor_gate_sweep_ctrl #(.DWELL(DWELL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .e        (e),
    .f        (f),
    .g        (g),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .fail_cnt (fail_cnt),
    .fail_vec (fail_vec),
    .err_mask (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test
  always_comb begin
    logic nor_v;
    nor_v = ~(a | b | c | d);
    {g, f, e} = {3{nor_v}} ^ flt[{a, b, c, d}];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 correct, 1 f stuck 0, 2 g stuck 1, 3 e built as OR, 4 random faults
  task automatic set_fault(input int mode);
    for (int v = 0; v < 16; v++) begin
      logic n;
      n = (v == 0);
      case (mode)
        1:       flt[v] = {1'b0, n, 1'b0};
        2:       flt[v] = {~n, 2'b00};
        3:       flt[v] = 3'b001;
        4:       flt[v] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        default: flt[v] = 3'b000;
      endcase
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_abcd"},     32'({a, b, c, d}), 32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_mismatch"}, 32'(mismatch),     32'd0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt),     32'd0);
    check({tag, "_fail_vec"}, 32'(fail_vec),     32'd0);
    check({tag, "_err_mask"}, 32'(err_mask),     32'd0);
  endtask

  // One sweep from IDLE/DONE; start high in cycle 0, optional re-pulse at
  // cycle 'repulse' while busy. Returns in cycle 16*DWELL+1 (done cycle).
  task automatic run_sweep(input string tag, input int repulse);
    int exp_cnt, exp_first, run_cnt, t;
    logic [2:0] exp_mask;
    exp_cnt = 0; exp_first = -1; exp_mask = 3'b000;
    for (int v = 0; v < 16; v++) begin
      if (flt[v] != 3'b000) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = v;
        exp_mask |= flt[v];
      end
    end
    if (exp_first < 0) exp_first = 0;

    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_c1_done"},     32'(done),     32'd0);
    check({tag, "_c1_fail_cnt"}, 32'(fail_cnt), 32'd0);
    check({tag, "_c1_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_c1_err_mask"}, 32'(err_mask), 32'd0);

    run_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < int'(DWELL); j++) begin
        t = 1 + k * int'(DWELL) + j;
        if (j == 0 && k > 0) begin
          if (flt[k-1] != 3'b000) run_cnt++;
          check({tag, "_run_cnt"}, 32'(fail_cnt), 32'(run_cnt));
        end
        check({tag, "_busy"}, 32'(busy),         32'd1);
        check({tag, "_vec"},  32'({a, b, c, d}), 32'(k));
        if (t == repulse) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end

    check({tag, "_end_busy"},     32'(busy),         32'd0);
    check({tag, "_end_done"},     32'(done),         32'd1);
    check({tag, "_end_abcd"},     32'({a, b, c, d}), 32'd0);
    check({tag, "_end_fail_cnt"}, 32'(fail_cnt),     32'(exp_cnt));
    check({tag, "_end_fail_vec"}, 32'(fail_vec),     32'(exp_first));
    check({tag, "_end_mismatch"}, 32'(mismatch),     32'(exp_cnt != 0));
    check({tag, "_end_err_mask"}, 32'(err_mask),     32'(exp_mask));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_fault(0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_zero("reset");

    set_fault(0); run_sweep("good", -1);
    set_fault(1); run_sweep("f_stuck0", -1);
    set_fault(2); run_sweep("g_stuck1", -1);
    set_fault(3); run_sweep("e_or", -1);
    set_fault(0); run_sweep("repulse", 20);
    set_fault(1); run_sweep("f_stuck0_b", -1);
    set_fault(0); run_sweep("after_err", -1);

    // Reset in the middle of a sweep, then a fresh sweep starting at cycle 40
    set_fault(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    #1;
    check_idle_zero("midrst");
    tick();
    rst = 1'b0;
    repeat (9) tick();
    run_sweep("post_rst", -1);

    for (int r = 0; r < 4; r++) begin
      set_fault(4);
      run_sweep($sformatf("rand%0d", r), int'($urandom_range(2, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_gate_sweep_ctrl.md
# nor_gate_sweep_ctrl

Sequencer that exhaustively exercises a four-input NOR datapath with inputs a, b, c, d and three parallel NOR outputs e, f, g. On a start pulse it walks all 16 input vectors, holds each for a programmable dwell, samples the three outputs against the expected NOR, and reports pass/fail status. It sits between the gate under test and board-level start/status logic (buttons/LEDs), replacing free-running testbench toggles with a synchronous, self-checking sweep.

## Interface

- DWELL, 4, clock cycles each vector is held; legal range 2..256
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; sampled in IDLE and DONE only
- e  input  1  NOR output 1 from datapath
- f  input  1  NOR output 2 from datapath
- g  input  1  NOR output 3 from datapath
- a  output  1  datapath input a = vec[3] (slowest toggling)
- b  output  1  datapath input b = vec[2]
- c  output  1  datapath input c = vec[1]
- d  output  1  datapath input d = vec[0] (fastest toggling)
- busy  output  1  high while sweep in progress
- done  output  1  high from sweep completion until next start
- mismatch  output  1  sticky: at least one vector failed in this sweep
- fail_cnt  output  5  number of failing vectors, 0..16
- fail_vec  output  4  first failing vector {a,b,c,d}; 0 if none
- err_mask  output  3  sticky per-output failure flags {g,f,e}

## Operation

- States: IDLE, RUN, DONE. One-hot or binary, implementer's choice.
- IDLE: a..d=0, busy=0, done=0. start=1 -> RUN; clears vec, dwell counter, fail_cnt, fail_vec, mismatch, err_mask.
- RUN: busy=1; {a,b,c,d} driven from registered 4-bit vec. Dwell counter counts 0..DWELL-1.
  - On dwell==DWELL-1 (sample cycle): expected x = ~(a|b|c|d); per output, error bit = (out != x). If any error bit: fail_cnt+1; if first failure in sweep, fail_vec<=vec; mismatch<=1; err_mask |= {g_err,f_err,e_err}.
  - After sample: dwell<=0, vec<=vec+1. If vec==15 at sample -> DONE (no wrap into a second pass).
- DONE: busy=0, done=1, a..d=0, status outputs hold. start=1 -> RUN with same clearing as from IDLE.
- start while RUN: ignored; no restart, no status change.
- fail_cnt saturation not required; 16 is maximum reachable and fits 5 bits.
- e/f/g are sampled directly (datapath is combinational, DWELL>=2 gives a full cycle of settling after vec change).

## Timing

- Reset (async assert, sync-safe release): state=IDLE; a,b,c,d,busy,done,mismatch=0; fail_cnt=0; fail_vec=0; err_mask=0.
- Reset mid-sweep: all of the above immediately; no status retained.
- Cycle 0: start=1 in IDLE. Cycle 1: busy=1, vec=0.
- Vector k driven cycles 1+k*DWELL .. (k+1)*DWELL; sampled on cycle (k+1)*DWELL.
- Status updates visible the cycle after each sample edge.
- Last sample cycle 16*DWELL; cycle 16*DWELL+1: busy=0, done=1. Total busy = 16*DWELL cycles.
- start held high continuously: one sweep per entry from IDLE/DONE; new sweep begins cycle after DONE is reached (done high for exactly one cycle then).

## Test plan

- Correct NOR on e,f,g, DWELL=4, start pulse at cycle 0 -> busy cycles 1..64, done=1 at cycle 65, fail_cnt=0, mismatch=0, fail_vec=0, err_mask=3'b000; a..d observed as 0000..1111 each held 4 cycles.
- f stuck at 0 -> only vector 0 fails: fail_cnt=1, fail_vec=4'h0, err_mask=3'b010, mismatch=1.
- g stuck at 1 -> vectors 1..15 fail: fail_cnt=15, fail_vec=4'h1, err_mask=3'b100.
- e implemented as OR (inverted) -> all 16 fail: fail_cnt=16 (5'b10000), fail_vec=4'h0, err_mask=3'b001.
- Correct gate, rst pulsed at cycle 30 then start at cycle 40 -> all outputs 0 immediately on rst; fresh sweep completes with done at cycle 105, fail_cnt=0.
- start re-pulsed at cycle 20 during RUN -> ignored, done still at cycle 65; then start in DONE after an error run with f stuck 0 -> status cleared at cycle after start, new sweep proceeds.
